// File: rtl/byte_word_packer_pkg.sv
// Shared constants and helpers for the byte-to-word packer and its consumers.
package byte_word_packer_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 32;
  localparam int LANES = 4;
  localparam int IDX_W = 2;

  // Byte lane that the idx-th byte of a word occupies.
  function automatic logic [IDX_W-1:0] lane_sel(input logic [IDX_W-1:0] idx,
                                                input logic             msb_first);
    logic [IDX_W-1:0] lane;
    if (msb_first) begin
      lane = 2'd3 - idx;
    end else begin
      lane = idx;
    end
    return lane;
  endfunction

  // Number of valid bytes described by a keep mask.
  function automatic logic [2:0] keep_count(input logic [LANES-1:0] keep);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + {2'b00, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/byte_word_packer_out.sv
// Output holding register for packed words: valid/ready hold, backpressure to
// the byte side and the completed-handshake counter.
import byte_word_packer_pkg::*;

module packer_out_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [OUT_W-1:0] load_bits,
  input  logic [LANES-1:0] load_keep,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_bits,
  output logic [LANES-1:0] out_keep,
  output logic             out_last,
  output logic [CNT_W-1:0] words,
  output logic             in_ready
);

  logic out_fire_s;

  // Handshake detect and upstream ready; a new word may load in the same
  // cycle the held one drains.
  always_comb begin
    out_fire_s = out_valid && out_ready;
    if (reset) begin
      in_ready = 1'b0;
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  // Holding register and word counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      words     <= '0;
    end else begin
      if (out_fire_s) begin
        words <= words + CNT_W'(1);
      end else begin
        words <= words;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_bits  <= load_bits;
        out_keep  <= load_keep;
        out_last  <= load_last;
      end else if (out_fire_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a ready/valid byte stream into 32-bit words with a keep mask; a word
// closes after four bytes or on an early last marker.
import byte_word_packer_pkg::*;

module byte_word_packer #(
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [IN_W-1:0]  io_in_bits,
  input  logic             io_in_last,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [OUT_W-1:0] io_out_bits,
  output logic [LANES-1:0] io_out_keep,
  output logic             io_out_last,
  output logic [CNT_W-1:0] io_words
);

  localparam bit MSB = (MSB_FIRST != 0);

  logic [OUT_W-1:0] acc_r;
  logic [LANES-1:0] kacc_r;
  logic [IDX_W-1:0] idx_r;

  logic [IDX_W-1:0] lane_s;
  logic [OUT_W-1:0] merged_acc_s;
  logic [LANES-1:0] merged_kacc_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             close_s;

  // Merge the incoming byte into its lane so a closing byte is part of the word.
  always_comb begin
    lane_s                          = lane_sel(idx_r, MSB);
    merged_acc_s                    = acc_r;
    merged_kacc_s                   = kacc_r;
    merged_acc_s[IN_W*lane_s +: IN_W] = io_in_bits;
    merged_kacc_s[lane_s]           = 1'b1;
    in_fire_s                       = io_in_valid && in_ready_s;
    close_s                         = in_fire_s && ((idx_r == 2'd3) || io_in_last);
  end

  // Accumulator, keep mask and lane index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r  <= '0;
      kacc_r <= '0;
      idx_r  <= '0;
    end else if (close_s) begin
      acc_r  <= '0;
      kacc_r <= '0;
      idx_r  <= '0;
    end else if (in_fire_s) begin
      acc_r  <= merged_acc_s;
      kacc_r <= merged_kacc_s;
      idx_r  <= idx_r + 2'd1;
    end else begin
      acc_r  <= acc_r;
      kacc_r <= kacc_r;
      idx_r  <= idx_r;
    end
  end

  packer_out_stage #(
    .CNT_W (CNT_W)
  ) u_out (
    .clock     (clock),
    .reset     (reset),
    .load      (close_s),
    .load_bits (merged_acc_s),
    .load_keep (merged_kacc_s),
    .load_last (io_in_last),
    .out_ready (io_out_ready),
    .out_valid (io_out_valid),
    .out_bits  (io_out_bits),
    .out_keep  (io_out_keep),
    .out_last  (io_out_last),
    .words     (io_words),
    .in_ready  (in_ready_s)
  );

  assign io_in_ready = in_ready_s;

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: LSB-first and MSB-first instances
// share one byte stream and are checked against a reference packing model.
module tb_byte_word_packer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_bits;
  logic        in_last;
  logic        out_ready;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [31:0] bits_a, bits_b;
  logic [3:0]  keep_a, keep_b;
  logic        last_a, last_b;
  logic [15:0] words_a, words_b;

  byte_word_packer #(.MSB_FIRST(0), .CNT_W(16)) dut_lsb (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready_a), .io_in_bits(in_bits), .io_in_last(in_last),
    .io_out_valid(out_valid_a), .io_out_ready(out_ready), .io_out_bits(bits_a),
    .io_out_keep(keep_a), .io_out_last(last_a), .io_words(words_a)
  );

  byte_word_packer #(.MSB_FIRST(1), .CNT_W(16)) dut_msb (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready_b), .io_in_bits(in_bits), .io_in_last(in_last),
    .io_out_valid(out_valid_b), .io_out_ready(out_ready), .io_out_bits(bits_b),
    .io_out_keep(keep_b), .io_out_last(last_b), .io_words(words_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] bl;
    logic [31:0] bm;
    logic [3:0]  kl;
    logic [3:0]  km;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          vcnt = 0;
  int          hs_count = 0;
  int          hs_cyc[$];
  int          mcnt = 0;
  logic [31:0] mbl = 32'd0, mbm = 32'd0;
  logic [3:0]  mkl = 4'd0, mkm = 4'd0;
  bit          acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mcnt = 0; mbl = 32'd0; mbm = 32'd0; mkl = 4'd0; mkm = 4'd0;
  endtask

  // Reference packing: byte n of a word goes to lane n (LSB-first) or 3-n (MSB-first).
  task automatic model_accept(input logic [7:0] b, input logic l);
    exp_t w;
    mbl[8*mcnt +: 8]     = b;
    mbm[8*(3-mcnt) +: 8] = b;
    mkl[mcnt]            = 1'b1;
    mkm[3-mcnt]          = 1'b1;
    mcnt++;
    if (mcnt == 4 || l) begin
      w.bl = mbl; w.bm = mbm; w.kl = mkl; w.km = mkm; w.last = l;
      sb.push_back(w);
      model_clear();
    end
  endtask

  // Called at a negedge with inputs already driven; observes the coming edge.
  task automatic tick(output bit accepted);
    #2;
    accepted = 1'b0;
    if (!reset) begin
      if (out_valid_a) vcnt++;
      if (out_valid_a && out_ready) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("bits_lsb", 64'(bits_a), 64'(e.bl));
          chk("keep_lsb", 64'(keep_a), 64'(e.kl));
          chk("last_lsb", 64'(last_a), 64'(e.last));
          chk("valid_msb", 64'(out_valid_b), 64'd1);
          chk("bits_msb", 64'(bits_b), 64'(e.bm));
          chk("keep_msb", 64'(keep_b), 64'(e.km));
          chk("last_msb", 64'(last_b), 64'(e.last));
        end
      end
      if (in_valid && in_ready_a) begin
        accepted = 1'b1;
        model_accept(in_bits, in_last);
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    bit a;
    a        = 1'b0;
    in_valid = 1'b1;
    in_bits  = b;
    in_last  = l;
    for (int i = 0; i < 50 && !a; i++) begin
      tick(a);
    end
    if (!a) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  // Asynchronous assertion between clock edges; partial and pending words die.
  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready_a), 64'd0);
    chk("rst_valid", 64'(out_valid_a), 64'd0);
    chk("rst_words", 64'(words_a), 64'd0);
    sb.delete();
    model_clear();
    hs_count = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bits = 8'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_in_ready", 64'(in_ready_a), 64'd0);
    chk("reset_valid", 64'(out_valid_a), 64'd0);
    chk("reset_bits", 64'(bits_a), 64'd0);
    chk("reset_keep", 64'(keep_a), 64'd0);
    chk("reset_last", 64'(last_a), 64'd0);
    chk("reset_words", 64'(words_a), 64'd0);
    reset = 1'b0;

    // Full word in both lane orders; valid must pulse for one cycle.
    vcnt = 0;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    idle(4);
    chk("t1_valid_cycles", 64'(vcnt), 64'd1);
    chk("t1_words", 64'(words_a), 64'd1);

    // Partial words closed by last.
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    idle(3);
    chk("t3_words", 64'(words_a), 64'(hs_count));

    // Backpressure: first word stalls while further bytes are offered.
    out_ready = 1'b0;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    in_valid = 1'b1; in_bits = 8'h01; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      chk("stall_in_ready", 64'(in_ready_a), 64'd0);
      chk("stall_valid", 64'(out_valid_a), 64'd1);
      chk("stall_bits", 64'(bits_a), 64'h44332211);
      chk("stall_keep", 64'(keep_a), 64'hF);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    idle(4);
    chk("t4_words", 64'(words_a), 64'(hs_count));
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Reset while a word is held: it is dropped and never counted.
    out_ready = 1'b0;
    send_byte(8'h09, 1'b1);
    idle(2);
    chk("pending_valid", 64'(out_valid_a), 64'd1);
    do_reset();
    out_ready = 1'b1;
    idle(2);
    chk("drop_words", 64'(words_a), 64'd0);
    chk("drop_valid", 64'(out_valid_a), 64'd0);

    // Back-to-back 8 bytes at full rate.
    vcnt = 0;
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), 1'b0);
    idle(4);
    chk("t5_valid_cycles", 64'(vcnt), 64'd2);
    chk("t5_hs_count", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() == 2) chk("t5_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'd4);
    chk("t5_words", 64'(words_a), 64'd2);
    chk("t5_words_msb", 64'(words_b), 64'd2);

    // Reset mid-word: aborted bytes vanish, next word starts at lane 0.
    send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0);
    do_reset();
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0);
    idle(4);
    chk("t6_words", 64'(words_a), 64'd1);
    chk("t6_hs_count", 64'(hs_count), 64'd1);
    chk("t6_bits", 64'(bits_a), 64'h88776655);
    chk("t6_keep", 64'(keep_a), 64'hF);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
